// File: rtl/mac_accum.sv
// Accumulation stage behind the pipelined multiplier: sums last-terminated product groups
// and delivers {value, beat count, saturation flag} through a 2-entry valid/ready buffer.
module mac_accum #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [IN_WIDTH-1:0]  i_prod,
  input  logic                 i_prod_valid,
  input  logic                 i_prod_last,
  input  logic                 i_clear,
  output logic [ACC_WIDTH-1:0] o_acc_val,
  output logic [CNT_WIDTH-1:0] o_acc_cnt,
  output logic                 o_acc_sat,
  output logic                 o_acc_valid,
  input  logic                 i_acc_ready,
  output logic                 o_busy,
  output logic                 o_drop_err
);

  localparam int EW = ACC_WIDTH + CNT_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sat_q, sat_d;

  logic                   fresh;
  logic [ACC_WIDTH-1:0]   base;
  logic [CNT_WIDTH-1:0]   cnt_base;
  logic [ACC_WIDTH:0]     sum_ext;
  logic                   ovf;
  logic                   push, pop;
  logic [EW-1:0]          entry_d;

  logic [EW-1:0]          head_q, tail_q;
  logic [1:0]             count_q;
  logic                   drop_q;

  // A beat starts a new group when nothing is open or when a clear aborts the open one.
  always_comb begin
    fresh    = (state_q == IDLE) | i_clear;
    base     = fresh ? '0 : acc_q;
    cnt_base = fresh ? '0 : cnt_q;
    sum_ext  = {base[ACC_WIDTH-1], base}
             + {{(ACC_WIDTH+1-IN_WIDTH){i_prod[IN_WIDTH-1]}}, i_prod};
    ovf      = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    acc_d    = sum_ext[ACC_WIDTH-1:0];
    if (ovf && SATURATE) begin
      acc_d = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    cnt_d    = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
    sat_d    = (~fresh & sat_q) | ovf;
    push     = i_prod_valid & i_prod_last;
    pop      = (count_q != 2'd0) & i_acc_ready;
    entry_d  = {acc_d, cnt_d, sat_d};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else if (i_prod_valid) begin
      if (i_prod_last) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
      end else begin
        state_q <= ACCUM;
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        sat_q   <= sat_d;
      end
    end else if (i_clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end
  end

  // Head slot always drives the outputs; a pop shifts the tail forward.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      drop_q  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= entry_d;
          end else begin
            head_q <= entry_d;
          end
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q  <= entry_d;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            tail_q  <= entry_d;
            count_q <= 2'd2;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_acc_val   = head_q[EW-1 -: ACC_WIDTH];
  assign o_acc_cnt   = head_q[CNT_WIDTH:1];
  assign o_acc_sat   = head_q[0];
  assign o_acc_valid = (count_q != 2'd0);
  assign o_busy      = (state_q == ACCUM);
  assign o_drop_err  = drop_q;

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an integer-arithmetic reference model.
module tb_mac_accum;

  localparam int IN_WIDTH  = 32;
  localparam int ACC_WIDTH = 40;
  localparam int CNT_WIDTH = 16;

  logic                        i_clk = 1'b0;
  logic                        i_rst;
  logic signed [IN_WIDTH-1:0]  i_prod;
  logic                        i_prod_valid;
  logic                        i_prod_last;
  logic                        i_clear;
  logic                        i_acc_ready;
  logic [ACC_WIDTH-1:0]        o_acc_val;
  logic [CNT_WIDTH-1:0]        o_acc_cnt;
  logic                        o_acc_sat;
  logic                        o_acc_valid;
  logic                        o_busy;
  logic                        o_drop_err;

  int checks = 0;
  int fails  = 0;

  mac_accum #(
    .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH), .SATURATE(1'b1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_prod(i_prod), .i_prod_valid(i_prod_valid),
    .i_prod_last(i_prod_last), .i_clear(i_clear), .o_acc_val(o_acc_val),
    .o_acc_cnt(o_acc_cnt), .o_acc_sat(o_acc_sat), .o_acc_valid(o_acc_valid),
    .i_acc_ready(i_acc_ready), .o_busy(o_busy), .o_drop_err(o_drop_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    longint val;
    longint cnt;
    bit     sat;
  } result_t;

  localparam longint ACC_MAX = (longint'(1) <<< (ACC_WIDTH-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_WIDTH-1));
  localparam longint CNT_MAX = (longint'(1) <<< CNT_WIDTH) - 1;

  result_t modelQ[$];
  longint  modelAcc     = 0;
  longint  modelCnt     = 0;
  bit      modelSat     = 1'b0;
  bit      modelOpen    = 1'b0;
  bit      modelDropErr = 1'b0;

  // Reference model: a group is an open running sum; results go to a 2-deep FIFO.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      modelQ.delete();
      modelAcc = 0; modelCnt = 0; modelSat = 1'b0; modelOpen = 1'b0; modelDropErr = 1'b0;
    end else begin
      longint  s;
      result_t r;
      bit      doPush;
      doPush = 1'b0;
      if (modelQ.size() > 0 && i_acc_ready) void'(modelQ.pop_front());
      if (i_clear || !modelOpen) begin
        modelAcc = 0; modelCnt = 0; modelSat = 1'b0; modelOpen = 1'b0;
      end
      if (i_prod_valid) begin
        s = modelAcc + longint'(i_prod);
        if (s > ACC_MAX) begin s = ACC_MAX; modelSat = 1'b1; end
        else if (s < ACC_MIN) begin s = ACC_MIN; modelSat = 1'b1; end
        modelAcc = s;
        if (modelCnt < CNT_MAX) modelCnt = modelCnt + 1;
        if (i_prod_last) begin
          r.val = modelAcc; r.cnt = modelCnt; r.sat = modelSat;
          doPush = 1'b1;
          modelAcc = 0; modelCnt = 0; modelSat = 1'b0; modelOpen = 1'b0;
        end else begin
          modelOpen = 1'b1;
        end
      end
      if (doPush) begin
        if (modelQ.size() < 2) modelQ.push_back(r);
        else modelDropErr = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return 2 time units after the capturing edge.
  task automatic applyStimulus(input bit valid, input bit last, input longint prod,
                               input bit clear, input bit ready);
    i_prod_valid = valid;
    i_prod_last  = last;
    i_prod       = IN_WIDTH'(prod);
    i_clear      = clear;
    i_acc_ready  = ready;
    @(posedge i_clk);
    #2;
  endtask

  always @(negedge i_clk) begin
    checkOutput("valid", longint'(o_acc_valid), longint'(modelQ.size() != 0));
    checkOutput("busy", longint'(o_busy), longint'(modelOpen));
    checkOutput("drop_err", longint'(o_drop_err), longint'(modelDropErr));
    if (modelQ.size() != 0 && o_acc_valid) begin
      checkOutput("head_val", longint'($signed(o_acc_val)), modelQ[0].val);
      checkOutput("head_cnt", longint'(o_acc_cnt), modelQ[0].cnt);
      checkOutput("head_sat", longint'(o_acc_sat), longint'(modelQ[0].sat));
    end
  end

  initial begin
    i_rst = 1'b1;
    i_prod = '0; i_prod_valid = 1'b0; i_prod_last = 1'b0; i_clear = 1'b0; i_acc_ready = 1'b1;
    @(posedge i_clk);
    #2;
    checkOutput("reset_valid", longint'(o_acc_valid), 0);
    checkOutput("reset_busy", longint'(o_busy), 0);
    checkOutput("reset_val", longint'(o_acc_val), 0);
    checkOutput("reset_drop", longint'(o_drop_err), 0);
    i_rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] group 3,5,-2");
    applyStimulus(1, 0, 3, 0, 1);
    applyStimulus(1, 0, 5, 0, 1);
    checkOutput("t1_not_yet_valid", longint'(o_acc_valid), 0);
    applyStimulus(1, 1, -2, 0, 1);
    checkOutput("t1_valid", longint'(o_acc_valid), 1);
    checkOutput("t1_val", longint'($signed(o_acc_val)), 6);
    checkOutput("t1_cnt", longint'(o_acc_cnt), 3);
    checkOutput("t1_sat", longint'(o_acc_sat), 0);

    $display("[TB] single beat then fresh group");
    applyStimulus(1, 1, 7, 0, 1);
    checkOutput("t2_val_a", longint'($signed(o_acc_val)), 7);
    checkOutput("t2_cnt_a", longint'(o_acc_cnt), 1);
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("t2_val_b", longint'($signed(o_acc_val)), 2);
    checkOutput("t2_cnt_b", longint'(o_acc_cnt), 2);

    $display("[TB] positive saturation");
    for (int i = 0; i < 299; i++) applyStimulus(1, 0, 64'h7FFFFFFF, 0, 1);
    applyStimulus(1, 1, 64'h7FFFFFFF, 0, 1);
    checkOutput("t3_val", longint'($signed(o_acc_val)), 64'h7F_FFFF_FFFF);
    checkOutput("t3_sat", longint'(o_acc_sat), 1);
    checkOutput("t3_cnt", longint'(o_acc_cnt), 300);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("t3_next_val", longint'($signed(o_acc_val)), 1);
    checkOutput("t3_next_sat", longint'(o_acc_sat), 0);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] full buffer drop");
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 2, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    checkOutput("t4_drop", longint'(o_drop_err), 1);
    checkOutput("t4_head1", longint'($signed(o_acc_val)), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_head2", longint'($signed(o_acc_val)), 2);
    checkOutput("t4_valid2", longint'(o_acc_valid), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_empty", longint'(o_acc_valid), 0);

    $display("[TB] clear with concurrent beat");
    applyStimulus(1, 0, 10, 0, 1);
    applyStimulus(1, 0, 20, 0, 1);
    checkOutput("t5_busy_before", longint'(o_busy), 1);
    applyStimulus(1, 1, 4, 1, 1);
    checkOutput("t5_val", longint'($signed(o_acc_val)), 4);
    checkOutput("t5_cnt", longint'(o_acc_cnt), 1);
    checkOutput("t5_busy_after", longint'(o_busy), 0);

    $display("[TB] asynchronous reset mid-group");
    applyStimulus(1, 1, 8, 0, 0);
    applyStimulus(1, 0, 5, 0, 0);
    #1 i_rst = 1'b1;
    #1;
    checkOutput("t6_valid", longint'(o_acc_valid), 0);
    checkOutput("t6_busy", longint'(o_busy), 0);
    checkOutput("t6_drop", longint'(o_drop_err), 0);
    checkOutput("t6_val", longint'(o_acc_val), 0);
    checkOutput("t6_cnt", longint'(o_acc_cnt), 0);
    i_rst = 1'b0;
    applyStimulus(1, 1, 9, 0, 1);
    checkOutput("t6_next_val", longint'($signed(o_acc_val)), 9);
    checkOutput("t6_next_cnt", longint'(o_acc_cnt), 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4000; i++) begin
      bit     v, l, c, r;
      longint p;
      v = ($urandom_range(0, 3) != 0);
      l = (i % 1000 < 400) ? ($urandom_range(0, 300) == 0) : ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 60) == 0);
      r = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 5))
        0:       p = 64'sh7FFFFFFF;
        1:       p = -64'sh80000000;
        2:       p = longint'($signed(32'($urandom)));
        default: p = longint'($urandom_range(0, 200)) - 100;
      endcase
      applyStimulus(v, l, p, c, r);
      if ($urandom_range(0, 700) == 0) begin
        #1 i_rst = 1'b1;
        #1 i_rst = 1'b0;
      end
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
